period_meter: RTL and testbench
===============================

// Module: period_meter
// PURPOSE
//   Measures the period and high time of a slow, asynchronous square wave in I_CLK cycles.
//   It is the inverse of the clock divider: given a divided/external clock, it recovers the divide ratio.
//   Used to check divider outputs and external clocks (e.g. MP3 decoder DREQ/BCLK) feeding the OLED/status path.
// PARAMETERS
//   CNT_W    16     width of the period/high counters and outputs
//   TIMEOUT  65535  maximum measurable period in I_CLK cycles; legal range 2..2^CNT_W-1
// PORTS
//   I_CLK     in   1      system clock, rising edge
//   rst_n     in   1      asynchronous reset, active low
//   clr       in   1      synchronous clear, active high; restarts the measurement
//   I_SIG     in   1      asynchronous signal to measure
//   O_PERIOD  out  CNT_W  last measured period (rising to rising), in cycles
//   O_HIGH    out  CNT_W  high time of that same period, in cycles
//   O_VALID   out  1      one-cycle pulse when O_PERIOD/O_HIGH update
//   O_STALL   out  1      level; high while no rising edge has arrived within TIMEOUT cycles
// BEHAVIOUR
//   Reset: all flops cleared; O_PERIOD=0, O_HIGH=0, O_VALID=0, O_STALL=0, state=WAIT_FIRST.
//   Input path: 2-flop synchronizer, then 1 delay flop for edge detect.
//     rise = s & ~s_d, fall = ~s & s_d. Latency from an I_SIG edge to rise/fall: 2-3 I_CLK cycles.
//     Latency is constant, so measured periods are exact for ideal inputs.
//   cnt (CNT_W): set to 1 on the rise cycle, otherwise +1 in MEASURE.
//   hcnt (CNT_W): set to 1 on rise; +1 while s=1 and no fall.
//     On fall, hcnt is latched into high_hold.
//   FSM states: WAIT_FIRST, MEASURE, STALLED.
//     WAIT_FIRST: on rise -> MEASURE; cnt=1, hcnt=1; no output.
//     MEASURE, rise: O_PERIOD<=cnt; O_HIGH<=high_hold; O_VALID<=1 next cycle; cnt=1, hcnt=1; stay.
//     MEASURE, no rise and cnt==TIMEOUT: -> STALLED; O_STALL<=1; cnt holds.
//     MEASURE, rise and cnt==TIMEOUT together: rise wins; period TIMEOUT is reported. This is the max legal period.
//     STALLED, rise: -> MEASURE; O_STALL<=0; cnt=1. No O_VALID, because the period is unknown.
//       O_PERIOD/O_HIGH keep their last valid values.
//   O_VALID is high for exactly one cycle per reported period; it is never high in the same cycle as a STALLED transition.
//   Counters never wrap: cnt stops at TIMEOUT, and hcnt saturates at TIMEOUT.
//   clr=1: -> WAIT_FIRST; cnt/hcnt/high_hold=0; O_VALID=0; O_STALL=0.
//     O_PERIOD/O_HIGH hold their values. clr has priority over a simultaneous rise/fall/timeout.
//     The synchronizer is not cleared by clr.
//   Async reset mid-measurement: takes effect immediately. The first report after release needs two rising edges.
//   A constant-high I_SIG gives the same stall behaviour as constant-low.
// TESTING
//   1. I_SIG = divider output with ratio 10, rst_n released: first O_VALID after 2nd rise.
//      Then O_PERIOD=10, O_HIGH=5, with O_VALID every 10 cycles.
//   2. TIMEOUT=100, I_SIG held low after one rise: O_STALL=1 exactly 100 cycles after that rise.
//      Next rise clears O_STALL with no O_VALID. Following rise gives a valid report.
//   3. TIMEOUT=100, I_SIG period exactly 100 (30 high): O_PERIOD=100, O_HIGH=30, O_STALL stays 0.
//      Period 101 -> stall.
//   4. clr asserted in the same cycle as a detected rise: no O_VALID.
//      state=WAIT_FIRST, O_PERIOD unchanged. Reports resume after two further rises.
//   5. rst_n pulsed low mid-period (not aligned to I_CLK): all outputs 0 immediately.
//      Recovery as in test 1.
//   6. Asymmetric wave, 3 high / 4 low (period 7): O_PERIOD=7, O_HIGH=3 on every report, no spurious O_VALID.

Source files
------------

// File: rtl/period_meter_if.sv
// Signal bundle for the period meter: control/measured input towards the meter,
// measurement results back from it.
interface period_meter_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             clr;
    logic             I_SIG;
    logic [CNT_W-1:0] O_PERIOD;
    logic [CNT_W-1:0] O_HIGH;
    logic             O_VALID;
    logic             O_STALL;

    // Side that drives the signal under test and consumes the results.
    modport master (
        output clr,
        output I_SIG,
        input  O_PERIOD,
        input  O_HIGH,
        input  O_VALID,
        input  O_STALL
    );

    // The meter itself.
    modport slave (
        input  clr,
        input  I_SIG,
        output O_PERIOD,
        output O_HIGH,
        output O_VALID,
        output O_STALL
    );
endinterface

// File: rtl/period_meter.sv
// Period / high-time meter for a slow asynchronous square wave, counted in I_CLK cycles.
// Reports rising-to-rising period and the high time inside it; flags a stall when no
// rising edge arrives within TIMEOUT cycles.
module period_meter #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic            I_CLK,
    input  logic            rst_n,
    period_meter_if.slave   pm
);

    typedef enum logic [1:0] {StWaitFirst, StMeasure, StStalled} state_e;

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    logic [1:0]       sync_q;
    logic             sig_d_q;
    logic             s, rise, fall;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             stall_q, stall_d;

    // Two-flop synchronizer plus one delay flop for edge detection; not affected by clr.
    always_ff @(posedge I_CLK or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            sig_d_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], pm.I_SIG};
            sig_d_q <= sync_q[1];
        end
    end

    assign s    = sync_q[1];
    assign rise = s & ~sig_d_q;
    assign fall = ~s & sig_d_q;

    // State, counters and result registers.
    always_ff @(posedge I_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StWaitFirst;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            hold_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            hold_q   <= hold_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            stall_q  <= stall_d;
        end
    end

    // Next-state logic: clr first, then high-time tracking, then the measurement FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        hold_d   = hold_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        stall_d  = stall_q;

        if (pm.clr) begin
            // Results are kept; only the measurement restarts.
            state_d = StWaitFirst;
            cnt_d   = '0;
            hcnt_d  = '0;
            hold_d  = '0;
            stall_d = 1'b0;
        end else begin
            if (state_q != StWaitFirst) begin
                if (fall) begin
                    hold_d = hcnt_q;
                end else if (s && (hcnt_q != TimeoutCnt)) begin
                    hcnt_d = hcnt_q + CntOne;
                end
            end

            unique case (state_q)
                StWaitFirst: begin
                    if (rise) begin
                        state_d = StMeasure;
                        cnt_d   = CntOne;
                        hcnt_d  = CntOne;
                    end
                end
                StMeasure: begin
                    // A rise landing on cnt==TIMEOUT still reports: that is the longest legal period.
                    if (rise) begin
                        period_d = cnt_q;
                        high_d   = hold_q;
                        valid_d  = 1'b1;
                        cnt_d    = CntOne;
                        hcnt_d   = CntOne;
                    end else if (cnt_q == TimeoutCnt) begin
                        state_d = StStalled;
                        stall_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StStalled: begin
                    // Period across a stall is unknown, so no report here.
                    if (rise) begin
                        state_d = StMeasure;
                        stall_d = 1'b0;
                        cnt_d   = CntOne;
                        hcnt_d  = CntOne;
                    end
                end
                default: begin
                    state_d = StWaitFirst;
                end
            endcase
        end
    end

    assign pm.O_PERIOD = period_q;
    assign pm.O_HIGH   = high_q;
    assign pm.O_VALID  = valid_q;
    assign pm.O_STALL  = stall_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with TIMEOUT=100.
module tb_period_meter;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 100;

    logic clk;
    logic rst_n;

    period_meter_if #(.CNT_W(CNT_W)) pm_if ();

    period_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .I_CLK (clk),
        .rst_n (rst_n),
        .pm    (pm_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Per-run observation statistics.
    int cyc;
    int n_valid;
    int n_bad;
    int first_valid;
    int first_stall;
    int exp_p;
    int exp_h;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats(input int p, input int h);
        cyc         = 0;
        n_valid     = 0;
        n_bad       = 0;
        first_valid = -1;
        first_stall = -1;
        exp_p       = p;
        exp_h       = h;
    endtask

    // Drive inputs for one cycle, then sample just after the rising edge.
    task automatic tick(input logic sig, input logic clr_v);
        pm_if.I_SIG = sig;
        pm_if.clr   = clr_v;
        @(posedge clk);
        #1;
        if (pm_if.O_VALID) begin
            n_valid++;
            if (first_valid < 0) first_valid = cyc;
            if (int'(pm_if.O_PERIOD) != exp_p || int'(pm_if.O_HIGH) != exp_h) n_bad++;
        end
        if (pm_if.O_STALL && first_stall < 0) first_stall = cyc;
        cyc++;
    endtask

    task automatic run_wave(input int high, input int low, input int periods);
        for (int p = 0; p < periods; p++) begin
            for (int i = 0; i < high; i++) tick(1'b1, 1'b0);
            for (int i = 0; i < low; i++) tick(1'b0, 1'b0);
        end
    endtask

    task automatic do_clr();
        tick(1'b0, 1'b1);
        pm_if.clr = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        pm_if.I_SIG = 1'b0;
        pm_if.clr   = 1'b0;
        clear_stats(0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_period", int'(pm_if.O_PERIOD), 0);
        check("rst_high", int'(pm_if.O_HIGH), 0);
        check("rst_valid", int'(pm_if.O_VALID), 0);
        check("rst_stall", int'(pm_if.O_STALL), 0);
        #3 rst_n = 1'b1;
        repeat (3) tick(1'b0, 1'b0);

        // Divide-by-10 wave: first report from the second rise, then every 10 cycles.
        clear_stats(10, 5);
        run_wave(5, 5, 6);
        check("div10_first", first_valid, 12);
        check("div10_count", n_valid, 5);
        check("div10_bad", n_bad, 0);
        check("div10_period", int'(pm_if.O_PERIOD), 10);
        check("div10_high", int'(pm_if.O_HIGH), 5);
        check("div10_stall", first_stall, -1);

        // Stall: one rise then low; O_STALL 100 edges after the edge that captured the rise.
        do_clr();
        clear_stats(10, 5);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 145; i++) tick(1'b0, 1'b0);
        check("stall_at", first_stall, 102);
        check("stall_novalid", n_valid, 0);
        clear_stats(10, 5);
        run_wave(5, 5, 3);
        check("unstall_first", first_valid, 12);
        check("unstall_count", n_valid, 2);
        check("unstall_bad", n_bad, 0);
        check("unstall_stall", int'(pm_if.O_STALL), 0);

        // Period exactly TIMEOUT is reported; TIMEOUT+1 stalls.
        do_clr();
        clear_stats(100, 30);
        run_wave(30, 70, 3);
        check("p100_count", n_valid, 2);
        check("p100_first", first_valid, 102);
        check("p100_bad", n_bad, 0);
        check("p100_stall", first_stall, -1);
        do_clr();
        clear_stats(101, 30);
        run_wave(30, 71, 2);
        check("p101_stall", first_stall, 102);
        check("p101_novalid", n_valid, 0);
        check("p101_keep", int'(pm_if.O_PERIOD), 100);

        // clr coincident with a detected rise suppresses the report.
        do_clr();
        clear_stats(10, 5);
        run_wave(5, 5, 2);
        clear_stats(10, 5);
        for (int i = 0; i < 10; i++) begin
            tick(i < 5, i == 2);
            if (i == 2) begin
                check("clr_valid", int'(pm_if.O_VALID), 0);
                check("clr_period", int'(pm_if.O_PERIOD), 10);
            end
        end
        run_wave(5, 5, 2);
        check("clr_resume_first", first_valid, 22);
        check("clr_resume_count", n_valid, 1);
        check("clr_resume_bad", n_bad, 0);

        // Asynchronous reset mid-period, not aligned to the clock.
        do_clr();
        clear_stats(10, 5);
        run_wave(5, 5, 3);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b0);
        check("pre_arst_period", int'(pm_if.O_PERIOD), 10);
        #2 rst_n = 1'b0;
        #1;
        check("arst_period", int'(pm_if.O_PERIOD), 0);
        check("arst_high", int'(pm_if.O_HIGH), 0);
        check("arst_valid", int'(pm_if.O_VALID), 0);
        check("arst_stall", int'(pm_if.O_STALL), 0);
        #3 rst_n = 1'b1;
        repeat (3) tick(1'b0, 1'b0);
        clear_stats(10, 5);
        run_wave(5, 5, 4);
        check("arst_rec_first", first_valid, 12);
        check("arst_rec_count", n_valid, 3);
        check("arst_rec_bad", n_bad, 0);

        // Asymmetric 3 high / 4 low.
        do_clr();
        clear_stats(7, 3);
        run_wave(3, 4, 6);
        check("asym_first", first_valid, 9);
        check("asym_count", n_valid, 5);
        check("asym_bad", n_bad, 0);
        check("asym_period", int'(pm_if.O_PERIOD), 7);
        check("asym_high", int'(pm_if.O_HIGH), 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
